fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 23 ++
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: memory read channel plus opcode channel to decode.
// master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ack;
  logic [7:0]  op;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_pc;
  logic        op_cb;

  modport master (
    output mem_rd, mem_addr, op, op_valid, op_pc, op_cb,
    input  mem_data, mem_ack, op_ready
  );

  modport slave (
    input  mem_rd, mem_addr, op, op_valid, op_pc, op_cb,
    output mem_data, mem_ack, op_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Byte prefetcher with 2-entry buffer; FETCH_CB_MERGE_EN merges 0xCB prefix with its operand.
// Latency: zero-wait ack presents the byte the next cycle; one read per cycle at best.
// Backpressure: op_ready low holds the head; reads stop once buffer + in-flight reach 2.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        pc_load,
  input  logic [15:0] pc_load_addr,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DISCARD = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [15:0] fetch_pc_q;
  logic [15:0] hold_addr_q;
  logic [7:0]  fifo_byte_q [2];
  logic [15:0] fifo_addr_q [2];
  logic [1:0]  count_q;
  logic [1:0]  count_pop;
  logic [1:0]  pop_n;
  logic        issue;
  logic        push;
  logic        xfer;
  logic        vld;
  logic        head_cb;
  logic [7:0]  op_byte;
  logic [15:0] op_addr;

  // An IDLE-cycle request is combinational so a zero-wait ack can land in that same cycle.
  assign issue     = (state_q == IDLE) && fetch_en && !pc_load && !rst && (count_q != 2'd2);
  assign push      = bus.mem_ack && ((state_q == REQ) || issue) && !pc_load;
  assign xfer      = vld && bus.op_ready && !pc_load;
  assign pop_n     = !xfer ? 2'd0 : (head_cb ? 2'd2 : 2'd1);
  assign count_pop = count_q - pop_n;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue && !bus.mem_ack) state_d = REQ;
      REQ:     if (bus.mem_ack) state_d = IDLE;
               else if (pc_load) state_d = DISCARD;
      DISCARD: if (bus.mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_rd   = issue || (!rst && (state_q != IDLE));
    // The abandoned read keeps its address on the bus while fetch_pc already points at the target.
    bus.mem_addr = (state_q == DISCARD) ? hold_addr_q : fetch_pc_q;
    vld     = 1'b0;
    head_cb = 1'b0;
    op_byte = 8'h00;
    op_addr = 16'h0000;
`ifdef FETCH_CB_MERGE_EN
    if (count_q != 2'd0 && fifo_byte_q[0] == 8'hCB) begin
      if (count_q == 2'd2) begin
        vld     = 1'b1;
        head_cb = 1'b1;
        op_byte = fifo_byte_q[1];
        op_addr = fifo_addr_q[0];
      end
    end else if (count_q != 2'd0) begin
      vld     = 1'b1;
      op_byte = fifo_byte_q[0];
      op_addr = fifo_addr_q[0];
    end
`else
    if (count_q != 2'd0) begin
      vld     = 1'b1;
      op_byte = fifo_byte_q[0];
      op_addr = fifo_addr_q[0];
    end
`endif
    bus.op_valid = vld;
    bus.op       = op_byte;
    bus.op_pc    = op_addr;
    bus.op_cb    = head_cb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q     <= 16'h0000;
      hold_addr_q    <= 16'h0000;
      count_q        <= 2'd0;
      fifo_byte_q[0] <= 8'h00;
      fifo_byte_q[1] <= 8'h00;
      fifo_addr_q[0] <= 16'h0000;
      fifo_addr_q[1] <= 16'h0000;
    end else if (pc_load) begin
      fetch_pc_q <= pc_load_addr;
      count_q    <= 2'd0;
      if (state_q == REQ) hold_addr_q <= fetch_pc_q;
    end else begin
      if (pop_n == 2'd1) begin
        fifo_byte_q[0] <= fifo_byte_q[1];
        fifo_addr_q[0] <= fifo_addr_q[1];
      end
      // Push lands after the pop shift, so it may overwrite slot 0 in the same cycle.
      if (push) begin
        fifo_byte_q[count_pop[0]] <= bus.mem_data;
        fifo_addr_q[count_pop[0]] <= fetch_pc_q;
        fetch_pc_q                <= fetch_pc_q + 16'd1;
      end
      count_q <= count_pop + {1'b0, push};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, corner sequences, random run vs. byte-stream model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        pc_load;
  logic [15:0] pc_load_addr;
  bit          rdy;
  bit          force_ack;
  int          lat = 0;
  int          wait_cnt = 0;
  int          mem_mode = 0;
  int          total = 0;
  int          bad = 0;
  logic [15:0] acked [$];

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (fetch_en),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] a, input int mode);
    if (mode == 0) begin
      if (a == 16'h0100) return 8'hCB;
      if (a == 16'h0101) return 8'h37;
      return a[7:0];
    end
    if (a[3:0] == 4'h7) return 8'hCB;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Memory: ack once the request has been held for 'lat' extra cycles (lat=0 is zero-wait).
  assign bus.mem_ack  = force_ack || (bus.mem_rd && wait_cnt >= lat);
  assign bus.mem_data = bus.mem_ack ? mem_byte(bus.mem_addr, mem_mode) : 8'h00;
  assign bus.op_ready = rdy;

  always @(posedge clk) wait_cnt <= (bus.mem_rd && !bus.mem_ack) ? wait_cnt + 1 : 0;
  always @(negedge clk) if (bus.mem_rd && bus.mem_ack) acked.push_back(bus.mem_addr);

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fetch_en = 1'b0; pc_load = 1'b0; rdy = 1'b0; force_ack = 1'b0;
    adv(); adv();
    rst = 1'b0;
  endtask

  typedef struct {
    bit fe; bit rdy; bit ld; logic [15:0] ld_addr;
    bit e_rd; logic [15:0] e_addr; bit e_vld; logic [7:0] e_op; logic [15:0] e_pc;
  } vec_t;

  typedef struct { logic [7:0] op; logic [15:0] pc; logic cb; } got_t;

  vec_t        tbl [13];
  got_t        got [$];
  int          n;
  bit          seen5;
  int          xfers;
  bit          prev_pend;
  logic [15:0] prev_addr;
  logic [15:0] exp_next;
  logic [15:0] step;
  logic [7:0]  b0, exp_op;
  logic        exp_cb;

  initial begin
    // zero-wait memory returning addr[7:0]; one row per cycle, outputs sampled before the edge
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 8'h00, 16'h0000};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b1, 8'h00, 16'h0000};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 8'h01, 16'h0001};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b1, 8'h02, 16'h0002};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 8'h02, 16'h0002};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 8'h02, 16'h0002};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 8'h03, 16'h0003};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b0, 8'h00, 16'h0000};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h0004, 1'b0, 8'h00, 16'h0000};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 8'h00, 16'h0000};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 8'hFF, 16'hFFFF};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b1, 8'h00, 16'h0000};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b0, 8'h00, 16'h0000};

    pc_load_addr = 16'h0000;
    do_reset();
    @(negedge clk);
    chk("rst mem_rd", bus.mem_rd, 1'b0);
    chk("rst mem_addr", bus.mem_addr, 16'h0000);
    chk("rst op", bus.op, 8'h00);
    chk("rst op_valid", bus.op_valid, 1'b0);
    chk("rst op_pc", bus.op_pc, 16'h0000);
    chk("rst op_cb", bus.op_cb, 1'b0);
    adv();

    for (int i = 0; i < 13; i++) begin
      fetch_en = tbl[i].fe; rdy = tbl[i].rdy; pc_load = tbl[i].ld; pc_load_addr = tbl[i].ld_addr;
      @(negedge clk);
      chk($sformatf("vec%0d mem_rd", i), bus.mem_rd, tbl[i].e_rd);
      chk($sformatf("vec%0d mem_addr", i), bus.mem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d op_valid", i), bus.op_valid, tbl[i].e_vld);
      chk($sformatf("vec%0d op", i), bus.op, tbl[i].e_op);
      if (tbl[i].e_vld) chk($sformatf("vec%0d op_pc", i), bus.op_pc, tbl[i].e_pc);
      adv();
    end
    pc_load = 1'b0;

    // stalled decode with 3-cycle memory: exactly two reads, then resume at 0x0002
    do_reset();
    lat = 2; acked.delete(); fetch_en = 1'b1; rdy = 1'b0;
    repeat (15) adv();
    @(negedge clk);
    chk("stall reads", acked.size(), 2);
    if (acked.size() == 2) begin
      chk("stall read0", acked[0], 16'h0000);
      chk("stall read1", acked[1], 16'h0001);
    end
    chk("stall mem_rd", bus.mem_rd, 1'b0);
    chk("stall op_valid", bus.op_valid, 1'b1);
    chk("stall op", bus.op, 8'h00);
    chk("stall op_pc", bus.op_pc, 16'h0000);
    rdy = 1'b1;
    adv();
    rdy = 1'b0;
    @(negedge clk);
    chk("stall next op", bus.op, 8'h01);
    chk("stall next op_pc", bus.op_pc, 16'h0001);
    rdy = 1'b1;
    adv();
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.mem_rd) break;
      adv();
    end
    chk("resume seen", n < 30, 1'b1);
    chk("resume addr", bus.mem_addr, 16'h0002);
    adv();
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.op_valid && bus.op_pc == 16'h0002) break;
      adv();
    end
    chk("resume op seen", n < 30, 1'b1);
    chk("resume op", bus.op, 8'h02);
    adv();

    // redirect while the read of 0x0005 is outstanding
    do_reset();
    lat = 3; fetch_en = 1'b1; rdy = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.mem_rd && bus.mem_addr == 16'h0005 && wait_cnt >= 1) break;
      adv();
    end
    chk("redir found read5", n < 100, 1'b1);
    pc_load = 1'b1; pc_load_addr = 16'h0150;
    adv();
    pc_load = 1'b0;
    @(negedge clk);
    chk("discard mem_rd", bus.mem_rd, 1'b1);
    chk("discard mem_addr", bus.mem_addr, 16'h0005);
    chk("discard op_valid", bus.op_valid, 1'b0);
    adv();
    seen5 = 1'b0;
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.op_valid && bus.op_pc == 16'h0005) seen5 = 1'b1;
      if (bus.mem_rd && bus.mem_addr == 16'h0150) break;
      adv();
    end
    chk("redir read 0150", n < 30, 1'b1);
    chk("redir 0005 presented", seen5, 1'b0);
    adv();
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.op_valid) break;
      adv();
    end
    chk("redir op_pc", bus.op_pc, 16'h0150);
    chk("redir op", bus.op, 8'h50);
    adv();

    // 0xCB prefix at 0x0100
    lat = 0; fetch_en = 1'b1; rdy = 1'b1;
    pc_load = 1'b1; pc_load_addr = 16'h0100;
    adv();
    pc_load = 1'b0;
    got.delete();
    for (n = 0; n < 20 && got.size() < 2; n++) begin
      @(negedge clk);
      if (bus.op_valid && rdy) got.push_back('{bus.op, bus.op_pc, bus.op_cb});
      adv();
    end
    chk("cb count", got.size(), 2);
    if (got.size() == 2) begin
`ifdef FETCH_CB_MERGE_EN
      chk("cb op0", got[0].op, 8'h37); chk("cb pc0", got[0].pc, 16'h0100); chk("cb cb0", got[0].cb, 1'b1);
      chk("cb op1", got[1].op, 8'h02); chk("cb pc1", got[1].pc, 16'h0102); chk("cb cb1", got[1].cb, 1'b0);
`else
      chk("cb op0", got[0].op, 8'hCB); chk("cb pc0", got[0].pc, 16'h0100); chk("cb cb0", got[0].cb, 1'b0);
      chk("cb op1", got[1].op, 8'h37); chk("cb pc1", got[1].pc, 16'h0101); chk("cb cb1", got[1].cb, 1'b0);
`endif
    end

    // reset during an outstanding read, stale ack afterwards
    do_reset();
    lat = 5; fetch_en = 1'b1; rdy = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.mem_rd && bus.mem_addr == 16'h0002 && wait_cnt >= 1) break;
      adv();
    end
    chk("rstreq found", n < 100, 1'b1);
    rst = 1'b1; fetch_en = 1'b0;
    adv();
    rst = 1'b0; force_ack = 1'b1;
    @(negedge clk);
    chk("rstreq mem_rd", bus.mem_rd, 1'b0);
    chk("rstreq mem_addr", bus.mem_addr, 16'h0000);
    chk("rstreq op_valid", bus.op_valid, 1'b0);
    chk("rstreq op", bus.op, 8'h00);
    chk("rstreq op_cb", bus.op_cb, 1'b0);
    chk("rstreq op_pc", bus.op_pc, 16'h0000);
    adv();
    force_ack = 1'b0;
    @(negedge clk);
    chk("rstreq no push", bus.op_valid, 1'b0);
    adv();
    fetch_en = 1'b1;
    @(negedge clk);
    chk("rstreq first rd", bus.mem_rd, 1'b1);
    chk("rstreq first addr", bus.mem_addr, 16'h0000);
    adv();

    // random run: every transfer must be the next instruction of the byte stream since the last redirect
    mem_mode = 1; lat = 1; xfers = 0; prev_pend = 1'b0; prev_addr = 16'h0000; exp_next = 16'h0000;
    for (int c = 0; c < 3000; c++) begin
      fetch_en     = ($urandom_range(0, 7) != 0);
      rdy          = ($urandom_range(0, 3) != 0);
      pc_load      = (c == 0) || ($urandom_range(0, 39) == 0);
      pc_load_addr = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
      if (!bus.mem_rd && $urandom_range(0, 15) == 0) lat = $urandom_range(0, 3);
      @(negedge clk);
      if (prev_pend) begin
        chk("hold mem_rd", bus.mem_rd, 1'b1);
        chk("hold mem_addr", bus.mem_addr, prev_addr);
      end
      prev_pend = bus.mem_rd && !bus.mem_ack;
      prev_addr = bus.mem_addr;
      if (!bus.op_valid) chk("idle op", bus.op, 8'h00);
      if (pc_load) begin
        exp_next = pc_load_addr;
      end else if (bus.op_valid && rdy) begin
        b0 = mem_byte(exp_next, 1);
        exp_op = b0; exp_cb = 1'b0; step = 16'd1;
`ifdef FETCH_CB_MERGE_EN
        if (b0 == 8'hCB) begin
          exp_op = mem_byte(16'(exp_next + 16'd1), 1); exp_cb = 1'b1; step = 16'd2;
        end
`endif
        chk("rand op", bus.op, exp_op);
        chk("rand op_pc", bus.op_pc, exp_next);
        chk("rand op_cb", bus.op_cb, exp_cb);
        exp_next = 16'(exp_next + step);
        xfers++;
      end
      adv();
    end
    pc_load = 1'b0;
    chk("rand liveness", xfers > 300, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
